bp_me_cfg_cmd_arbiter: RTL and testbench
========================================

// Module: bp_me_cfg_cmd_arbiter
// PURPOSE
// Shares one BedRock I/O command stream (cfg/MMIO path into tile cfg devices)
// between num_req_p requesters, e.g. the CCE ucode/cfg loader and a host debug loader.
// Round-robin arbitration with message lock until the last beat, and a global
// outstanding-message credit limit. In-order response steering back to the issuing requester.
// PARAMETERS
// bp_params_p    e_bp_default_cfg  proc params; supplies paddr/did/lce widths, mem_header_width_lp
// num_req_p      2                 number of requesters, >=2
// data_width_p   64                stream data beat width (dword_width_gp)
// max_credits_p  16                max outstanding cmd messages (io_noc_max_credits_p)
// PORTS
// clk_i              in   1                  clock
// reset_n_i          in   1                  reset, asynchronous, active-low
// req_header_i       in   num_req_p*hdr      per-requester bp_bedrock_mem_header_s
// req_data_i         in   num_req_p*data     per-requester data beat
// req_v_i            in   num_req_p          requester beat valid
// req_last_i         in   num_req_p          requester final beat of message
// req_yumi_o         out  num_req_p          beat consumed (one-hot or zero)
// io_cmd_header_o    out  hdr                granted header
// io_cmd_data_o      out  data               granted data
// io_cmd_v_o         out  1                  cmd valid
// io_cmd_last_o      out  1                  cmd last beat
// io_cmd_ready_and_i in   1                  downstream ready
// io_resp_header_i   in   hdr  / io_resp_data_i in data / io_resp_v_i in 1 / io_resp_last_i in 1
// io_resp_ready_and_o out 1                  resp accepted upstream
// resp_header_o, resp_data_o, resp_last_o  out  hdr/data/1  broadcast to all requesters
// resp_v_o           out  num_req_p          one-hot valid to owning requester
// resp_ready_and_i   in   num_req_p          requester resp ready
// credits_empty_o    out  1                  no messages outstanding
// credits_full_o     out  1                  max_credits_p messages outstanding
// BEHAVIOUR
// - Reset (reset_n_i=0, async): state=e_idle, rr pointer=0, credits=0, tag tracker empty.
//   All v/yumi outputs 0, credits_empty_o=1, credits_full_o=0.
// - Beat handshake: accept = io_cmd_v_o & io_cmd_ready_and_i; req_yumi_o[g] = accept.
//   Zero-cycle pass-through; no storage on the cmd path.
// - e_idle: g = first req_v_i at/after rr pointer (wrap mod num_req_p).
//   io_cmd_v_o = |req_v_i & ~credits_full_o & ~tracker_full.
//   On accept: push g to tracker, credits+1.
//   If last=1: stay e_idle, rr=g+1 mod N. Else: e_locked, grant_r=g.
// - e_locked: only grant_r forwarded; credit/full NOT checked (continuation beats).
//   On accept with last=1: e_idle, rr=grant_r+1 mod N. Other requesters' req_v_i ignored.
// - Response: owner h = tracker head. resp_v_o = onehot(h) & {N{io_resp_v_i & tracker_v}}.
//   io_resp_ready_and_o = tracker_v & resp_ready_and_i[h].
//   Accepted last response beat pops tracker, credits-1.
// - Simultaneous first-beat accept and last-resp pop: credits unchanged, tracker push+pop legal.
// - credits_full_o: count==max_credits_p. Counter width `BSG_WIDTH(max_credits_p); no wrap.
// - io_resp_v_i with tracker empty: ready held 0, sim assertion fires.
// - Requester dropping req_v_i mid-message in e_locked: legal, lock held.
// - Reset mid-message: message abandoned, all state cleared; no recovery beat sent.
// STRUCTURE
// - bp_me_pkg: typedef enum logic {e_cfg_arb_idle, e_cfg_arb_locked} bp_cfg_arb_state_e.
// - Sub-module bp_me_cfg_arb_tracker: async-active-low-reset FIFO.
//   Depth max_credits_p, width `BSG_SAFE_CLOG2(num_req_p); outputs head/v/full/empty.
//   Credit count derived from its occupancy.
// - Round-robin select: bsg_arb_round_robin-equivalent logic inline. Pointer updates only at message end.
// TESTING
// - Post-reset: outputs v=0, credits_empty_o=1.
//   req_v_i=2'b11, single-beat -> req0 granted first, then req1, alternating.
// - req0 3-beat msg (last on beat 3), req1 valid throughout -> io_cmd carries req0 x3 contiguous.
//   req1 granted only after req0's last beat.
// - max_credits_p=16: issue 16 single-beat msgs, no resp -> credits_full_o=1, io_cmd_v_o=0.
//   One resp -> next msg issues the following cycle.
// - Interleaved issue req0,req1,req0; three resps -> resp_v_o = 01,10,01 in order.
//   resp_ready_and_i[1]=0 stalls io_resp_ready_and_o.
// - Same-cycle first-beat accept and last-resp accept at count=5 -> count stays 5.
// - Assert reset_n_i low mid 3-beat msg -> next cycle all v=0, credits=0, rr=0.

Source files
------------

// File: rtl/bp_me_cfg_cmd_arbiter_pkg.sv
// Shared types and helpers for the cfg command arbiter: BedRock header layout,
// arbiter state encoding and width helpers.
package bp_me_cfg_cmd_arbiter_pkg;

  typedef struct packed {
    logic [3:0]  msg_type;
    logic [2:0]  size;
    logic [39:0] addr;
    logic [7:0]  payload;
  } bp_bedrock_mem_header_s;

  typedef enum logic {e_cfg_arb_idle, e_cfg_arb_locked} bp_cfg_arb_state_e;

  localparam logic [0:0] e_idle   = 1'b0;
  localparam logic [0:0] e_locked = 1'b1;

  // Index width that never collapses to zero bits.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_me_cfg_cmd_arbiter_if.sv
// Bundle of the requester-side and I/O-side streams around the cfg command arbiter.
// Every stream beat transfers on a cycle where valid and ready_and (or yumi) are both 1;
// valid never depends on ready, and yumi is asserted only for a beat actually taken.
interface bp_me_cfg_cmd_arbiter_if
  import bp_me_cfg_cmd_arbiter_pkg::*;
  #(parameter int num_req_p    = 2,
    parameter int data_width_p = 64);

  bp_bedrock_mem_header_s [num_req_p-1:0]                   req_header;
  logic                   [num_req_p-1:0][data_width_p-1:0] req_data;
  logic                   [num_req_p-1:0]                   req_v;
  logic                   [num_req_p-1:0]                   req_last;
  logic                   [num_req_p-1:0]                   req_yumi;

  bp_bedrock_mem_header_s  io_cmd_header;
  logic [data_width_p-1:0] io_cmd_data;
  logic                    io_cmd_v;
  logic                    io_cmd_last;
  logic                    io_cmd_ready_and;

  bp_bedrock_mem_header_s  io_resp_header;
  logic [data_width_p-1:0] io_resp_data;
  logic                    io_resp_v;
  logic                    io_resp_last;
  logic                    io_resp_ready_and;

  bp_bedrock_mem_header_s  resp_header;
  logic [data_width_p-1:0] resp_data;
  logic                    resp_last;
  logic [num_req_p-1:0]    resp_v;
  logic [num_req_p-1:0]    resp_ready_and;

  modport master (
    input  req_header, req_data, req_v, req_last,
    output req_yumi,
    output io_cmd_header, io_cmd_data, io_cmd_v, io_cmd_last,
    input  io_cmd_ready_and,
    input  io_resp_header, io_resp_data, io_resp_v, io_resp_last,
    output io_resp_ready_and,
    output resp_header, resp_data, resp_last, resp_v,
    input  resp_ready_and
  );

  modport slave (
    output req_header, req_data, req_v, req_last,
    input  req_yumi,
    input  io_cmd_header, io_cmd_data, io_cmd_v, io_cmd_last,
    output io_cmd_ready_and,
    output io_resp_header, io_resp_data, io_resp_v, io_resp_last,
    input  io_resp_ready_and,
    input  resp_header, resp_data, resp_last, resp_v,
    output resp_ready_and
  );

endinterface

// File: rtl/bp_me_cfg_cmd_arbiter_tracker.sv
// In-order owner FIFO: one entry per outstanding command message, holding the
// index of the requester that issued it. Occupancy doubles as the credit count.
module bp_me_cfg_cmd_arbiter_tracker
  import bp_me_cfg_cmd_arbiter_pkg::*;
  #(parameter int depth_p = 16,
    parameter int width_p = 1,
    localparam int ptr_w_lp = safe_clog2(depth_p),
    localparam int cnt_w_lp = $clog2(depth_p + 1))
  (input  logic                clk,
   input  logic                rst_n,
   input  logic                push,
   input  logic [width_p-1:0]  push_data,
   input  logic                pop,
   output logic [width_p-1:0]  head,
   output logic                v,
   output logic                full,
   output logic                empty,
   output logic [cnt_w_lp-1:0] count);

  logic [width_p-1:0]  mem [depth_p];
  logic [ptr_w_lp-1:0] wr_ptr, rd_ptr;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(depth_p - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == cnt_w_lp'(depth_p));
  assign v     = ~empty;

endmodule

// File: rtl/bp_me_cfg_cmd_arbiter.sv
// Round-robin arbiter sharing one BedRock cfg/MMIO command stream between requesters,
// with per-message lock, outstanding-message credits and in-order response steering.
module bp_me_cfg_cmd_arbiter
  import bp_me_cfg_cmd_arbiter_pkg::*;
  #(parameter int num_req_p     = 2,
    parameter int data_width_p  = 64,
    parameter int max_credits_p = 16,
    localparam int lg_req_lp    = safe_clog2(num_req_p),
    localparam int cred_w_lp    = $clog2(max_credits_p + 1))
  (input  logic                  clk_i,
   input  logic                  reset_n_i,
   bp_me_cfg_cmd_arbiter_if.master bus,
   output logic                  credits_empty_o,
   output logic                  credits_full_o,
   output logic [cred_w_lp-1:0]  credits_o,
   output bp_cfg_arb_state_e     state_o,
   output logic [lg_req_lp-1:0]  rr_o);

  localparam logic [num_req_p-1:0] one_lp = {{(num_req_p-1){1'b0}}, 1'b1};

  logic [0:0]              state_r, state_n;
  logic [lg_req_lp-1:0]    rr_r, rr_n, grant_r, grant_n, rr_sel, sel, sel_inc, head;
  logic                    accept, push, pop, tracker_v, tracker_full, tracker_empty;
  logic [data_width_p-1:0] cmd_data;
  int                      idx;

  // First valid requester at or after the rr pointer; scanning from the far end
  // lets the closest one win.
  always_comb begin
    rr_sel = rr_r;
    idx    = 0;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      idx = int'(rr_r) + i;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (bus.req_v[idx]) rr_sel = lg_req_lp'(idx);
    end
  end

  always_comb begin
    sel     = (state_r == e_locked) ? grant_r : rr_sel;
    sel_inc = (sel == lg_req_lp'(num_req_p - 1)) ? '0 : sel + 1'b1;
    // Continuation beats bypass the credit check: their message already holds one.
    if (state_r == e_locked) bus.io_cmd_v = reset_n_i & bus.req_v[grant_r];
    else                     bus.io_cmd_v = reset_n_i & (|bus.req_v) & ~tracker_full;
    cmd_data          = bus.req_data[sel];
    bus.io_cmd_data   = cmd_data;
    bus.io_cmd_header = bus.req_header[sel];
    bus.io_cmd_last   = bus.req_last[sel];
    accept            = bus.io_cmd_v & bus.io_cmd_ready_and;
    bus.req_yumi      = accept ? (one_lp << sel) : '0;
    push              = accept & (state_r == e_idle);
  end

  always_comb begin
    state_n = state_r;
    rr_n    = rr_r;
    grant_n = grant_r;
    if (accept) begin
      if (bus.io_cmd_last) begin
        state_n = e_idle;
        rr_n    = sel_inc;
      end else if (state_r == e_idle) begin
        state_n = e_locked;
        grant_n = sel;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_idle;
      rr_r    <= '0;
      grant_r <= '0;
    end else begin
      state_r <= state_n;
      rr_r    <= rr_n;
      grant_r <= grant_n;
    end
  end

  always_comb begin
    bus.resp_header       = bus.io_resp_header;
    bus.resp_data         = bus.io_resp_data;
    bus.resp_last         = bus.io_resp_last;
    bus.resp_v            = (bus.io_resp_v & tracker_v) ? (one_lp << head) : '0;
    bus.io_resp_ready_and = tracker_v & bus.resp_ready_and[head];
    pop                   = bus.io_resp_v & bus.io_resp_ready_and & bus.io_resp_last;
  end

  bp_me_cfg_cmd_arbiter_tracker #(
    .depth_p (max_credits_p),
    .width_p (lg_req_lp)
  ) tracker (
    .clk       (clk_i),
    .rst_n     (reset_n_i),
    .push      (push),
    .push_data (sel),
    .pop       (pop),
    .head      (head),
    .v         (tracker_v),
    .full      (tracker_full),
    .empty     (tracker_empty),
    .count     (credits_o)
  );

  assign credits_empty_o = tracker_empty;
  assign credits_full_o  = tracker_full;
  assign state_o         = bp_cfg_arb_state_e'(state_r);
  assign rr_o            = rr_r;

  resp_without_owner: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(bus.io_resp_v && tracker_empty));

endmodule

// File: tb/tb_bp_me_cfg_cmd_arbiter.sv
// Directed bench for the cfg command arbiter: round-robin, lock, credits,
// in-order response steering and asynchronous reset mid-message.
module tb_bp_me_cfg_cmd_arbiter;
  import bp_me_cfg_cmd_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int DW = 64;
  localparam int MC = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bp_me_cfg_cmd_arbiter_if #(.num_req_p(N), .data_width_p(DW)) bus ();

  logic              credits_empty, credits_full;
  logic [4:0]        credits;
  bp_cfg_arb_state_e state;
  logic [0:0]        rr;

  bp_me_cfg_cmd_arbiter #(
    .num_req_p     (N),
    .data_width_p  (DW),
    .max_credits_p (MC)
  ) dut (
    .clk_i           (clk),
    .reset_n_i       (rst_n),
    .bus             (bus.master),
    .credits_empty_o (credits_empty),
    .credits_full_o  (credits_full),
    .credits_o       (credits),
    .state_o         (state),
    .rr_o            (rr)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [N-1:0] exp_q[$];   // expected owner (one-hot resp_v) per issued message

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int i, input int beat);
    return {32'(i + 1), 32'(beat)};
  endfunction

  task automatic set_req(input int i, input logic v, input logic last, input int beat);
    bus.req_v[i]      = v;
    bus.req_last[i]   = last;
    bus.req_data[i]   = beat_data(i, beat);
    bus.req_header[i] = '{msg_type: 4'h1, size: 3'h3, addr: 40'(i * 256 + beat), payload: 8'h0};
  endtask

  task automatic set_resp(input logic v, input logic last);
    bus.io_resp_v      = v;
    bus.io_resp_last   = last;
    bus.io_resp_data   = 64'hBEEF0001;
    bus.io_resp_header = '0;
  endtask

  // Pops one expected owner and compares it with the steered resp_v.
  task automatic chk_owner(input string tag);
    logic [N-1:0] exp;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed %0h expected <empty scoreboard>", tag, bus.resp_v);
    end else begin
      exp = exp_q.pop_front();
      chk(tag, 64'(bus.resp_v), 64'(exp));
    end
  endtask

  initial begin
    bus.req_v = '0; bus.req_last = '0; bus.req_data = '0; bus.req_header = '0;
    bus.io_cmd_ready_and = 1'b1;
    bus.resp_ready_and   = 2'b11;
    set_resp(1'b0, 1'b0);
    set_req(0, 1'b1, 1'b1, 0);
    set_req(1, 1'b1, 1'b1, 0);

    // Reset holds every valid low even with requesters asking.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cmd_v", 64'(bus.io_cmd_v), 64'd0);
    chk("rst_yumi", 64'(bus.req_yumi), 64'd0);
    chk("rst_resp_v", 64'(bus.resp_v), 64'd0);
    chk("rst_resp_ready", 64'(bus.io_resp_ready_and), 64'd0);
    chk("rst_empty", 64'(credits_empty), 64'd1);
    chk("rst_full", 64'(credits_full), 64'd0);

    // Round-robin single-beat messages: 0, 1, 0.
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rr0_yumi", 64'(bus.req_yumi), 64'd1);
    chk("rr0_data", bus.io_cmd_data, beat_data(0, 0));
    exp_q.push_back(2'b01);
    @(negedge clk); #1;
    chk("rr1_yumi", 64'(bus.req_yumi), 64'd2);
    chk("rr1_data", bus.io_cmd_data, beat_data(1, 0));
    exp_q.push_back(2'b10);
    @(negedge clk); #1;
    chk("rr2_yumi", 64'(bus.req_yumi), 64'd1);
    exp_q.push_back(2'b01);
    @(negedge clk); bus.req_v = '0; #1;
    chk("issue3_credits", 64'(credits), 64'd3);
    chk("issue3_empty", 64'(credits_empty), 64'd0);
    chk("idle_cmd_v", 64'(bus.io_cmd_v), 64'd0);

    // In-order responses, with a stall when the owner is not ready.
    set_resp(1'b1, 1'b1); #1;
    chk_owner("resp0_v");
    chk("resp0_ready", 64'(bus.io_resp_ready_and), 64'd1);
    chk("resp0_data", bus.resp_data, 64'hBEEF0001);
    @(negedge clk); bus.resp_ready_and = 2'b01; #1;
    chk("resp1_stall_v", 64'(bus.resp_v), 64'(exp_q[0]));
    chk("resp1_stall_ready", 64'(bus.io_resp_ready_and), 64'd0);
    @(negedge clk); bus.resp_ready_and = 2'b11; #1;
    chk_owner("resp1_v");
    chk("resp1_ready", 64'(bus.io_resp_ready_and), 64'd1);
    @(negedge clk); #1;
    chk_owner("resp2_v");
    @(negedge clk); set_resp(1'b0, 1'b0); #1;
    chk("drain_empty", 64'(credits_empty), 64'd1);

    // Message lock: req0 three beats, req1 waits; req0 drops valid mid-message.
    set_req(0, 1'b1, 1'b0, 1); bus.req_v[1] = 1'b0; #1;
    chk("lock_b1_yumi", 64'(bus.req_yumi), 64'd1);
    chk("lock_b1_last", 64'(bus.io_cmd_last), 64'd0);
    exp_q.push_back(2'b01);
    @(negedge clk); set_req(0, 1'b1, 1'b0, 2); set_req(1, 1'b1, 1'b1, 0); #1;
    chk("lock_state", 64'(state), 64'(e_cfg_arb_locked));
    chk("lock_b2_yumi", 64'(bus.req_yumi), 64'd1);
    chk("lock_b2_data", bus.io_cmd_data, beat_data(0, 2));
    @(negedge clk); bus.req_v[0] = 1'b0; #1;
    chk("lock_gap_v", 64'(bus.io_cmd_v), 64'd0);
    chk("lock_gap_yumi", 64'(bus.req_yumi), 64'd0);
    @(negedge clk); set_req(0, 1'b1, 1'b1, 3); #1;
    chk("lock_b3_yumi", 64'(bus.req_yumi), 64'd1);
    chk("lock_b3_last", 64'(bus.io_cmd_last), 64'd1);
    chk("lock_b3_data", bus.io_cmd_data, beat_data(0, 3));
    @(negedge clk); bus.req_v[0] = 1'b0; #1;
    chk("after_lock_state", 64'(state), 64'(e_cfg_arb_idle));
    chk("after_lock_yumi", 64'(bus.req_yumi), 64'd2);
    chk("after_lock_addr", 64'(bus.io_cmd_header.addr), 64'h100);
    exp_q.push_back(2'b10);
    @(negedge clk); bus.req_v = '0;

    // Two-beat response only pops on its last beat.
    set_resp(1'b1, 1'b0); #1;
    chk("mb_resp_v", 64'(bus.resp_v), 64'(exp_q[0]));
    @(negedge clk); set_resp(1'b1, 1'b1); #1;
    chk("mb_resp_credits", 64'(credits), 64'd2);
    chk_owner("mb_resp_last_v");
    @(negedge clk); #1;
    chk_owner("resp_req1_v");
    @(negedge clk); set_resp(1'b0, 1'b0); #1;
    chk("lock_drain_credits", 64'(credits), 64'd0);

    // Fill every credit; the next message waits for a response.
    for (int i = 0; i < MC; i++) begin
      @(negedge clk); set_req(0, 1'b1, 1'b1, i); #1;
      chk("fill_yumi", 64'(bus.req_yumi), 64'd1);
      exp_q.push_back(2'b01);
    end
    @(negedge clk); #1;
    chk("full_flag", 64'(credits_full), 64'd1);
    chk("full_credits", 64'(credits), 64'd16);
    chk("full_cmd_v", 64'(bus.io_cmd_v), 64'd0);
    set_resp(1'b1, 1'b1); #1;
    chk("full_resp_cmd_v", 64'(bus.io_cmd_v), 64'd0);
    chk_owner("full_resp_v");
    @(negedge clk); set_resp(1'b0, 1'b0); #1;
    chk("refill_full", 64'(credits_full), 64'd0);
    chk("refill_yumi", 64'(bus.req_yumi), 64'd1);
    exp_q.push_back(2'b01);

    // Drain down to five outstanding.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk); bus.req_v = '0; set_resp(1'b1, 1'b1); #1;
      chk_owner("drain_v");
    end
    @(negedge clk); set_resp(1'b0, 1'b0); #1;
    chk("count5", 64'(credits), 64'd5);

    // Same-cycle first-beat push and last-response pop.
    set_req(0, 1'b1, 1'b1, 7); set_resp(1'b1, 1'b1); #1;
    chk("pp_yumi", 64'(bus.req_yumi), 64'd1);
    chk("pp_resp_ready", 64'(bus.io_resp_ready_and), 64'd1);
    chk_owner("pp_resp_v");
    exp_q.push_back(2'b01);
    @(negedge clk); bus.req_v = '0; set_resp(1'b0, 1'b0); #1;
    chk("pp_count", 64'(credits), 64'd5);

    // Reset in the middle of a three-beat message.
    set_req(0, 1'b1, 1'b0, 1); #1;
    chk("mid_b1_yumi", 64'(bus.req_yumi), 64'd1);
    @(negedge clk); set_req(0, 1'b1, 1'b0, 2); #1;
    chk("mid_b2_state", 64'(state), 64'(e_cfg_arb_locked));
    chk("mid_b2_credits", 64'(credits), 64'd6);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("mid_rst_cmd_v", 64'(bus.io_cmd_v), 64'd0);
    chk("mid_rst_yumi", 64'(bus.req_yumi), 64'd0);
    chk("mid_rst_credits", 64'(credits), 64'd0);
    chk("mid_rst_empty", 64'(credits_empty), 64'd1);
    chk("mid_rst_state", 64'(state), 64'(e_cfg_arb_idle));
    chk("mid_rst_rr", 64'(rr), 64'd0);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1; set_req(0, 1'b1, 1'b1, 0); set_req(1, 1'b1, 1'b1, 0); #1;
    chk("post_rst_yumi", 64'(bus.req_yumi), 64'd1);
    @(negedge clk); bus.req_v = '0; #1;
    chk("post_rst_credits", 64'(credits), 64'd1);
    chk("post_rst_state", 64'(state), 64'(e_cfg_arb_idle));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
